// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter for the shared data-memory bus.
// RAM accesses take one bus cycle, I/O accesses add IO_WAIT cycles, and unmapped accesses return zero.
module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int IO_WAIT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
    output logic              s_we,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic [DATA_W-1:0] s_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    localparam logic [3:0] IO_WAIT_CNT = 4'(IO_WAIT);

    state_t            state;
    logic              last_grant;
    logic              grant;
    logic [3:0]        wait_cnt;

    logic              pick;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              s_unmapped;

    function automatic logic is_ram(input logic [ADDR_W-1:0] a);
        return a <= ADDR_W'(32'h0000_00FF);
    endfunction

    function automatic logic is_io(input logic [ADDR_W-1:0] a);
        return (a >= ADDR_W'(32'h0000_0100)) && (a <= ADDR_W'(32'h0000_01FF));
    endfunction

    // Requester selection: a contested cycle goes to whoever was not granted last.
    always_comb begin
        // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
        pick = 1'b0;
        if (m0_req && m1_req)
            pick = ~last_grant;
        else if (m1_req)
            pick = 1'b1;
        sel_we    = pick ? m1_we    : m0_we;
        sel_addr  = pick ? m1_addr  : m0_addr;
        sel_wdata = pick ? m1_wdata : m0_wdata;
    end

    assign s_unmapped = !is_ram(s_addr) && !is_io(s_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            wait_cnt   <= '0;
            s_we       <= 1'b0;
            s_addr     <= '0;
            s_wdata    <= '0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
            busy       <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only; the later assignment in a branch wins.
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        grant    <= pick;
                        s_addr   <= sel_addr;
                        s_wdata  <= sel_wdata;
                        s_we     <= sel_we && (is_ram(sel_addr) || is_io(sel_addr));
                        wait_cnt <= is_io(sel_addr) ? IO_WAIT_CNT : 4'd0;
                        busy     <= 1'b1;
                        state    <= ACCESS;
                        if (m0_req && m1_req)
                            last_grant <= pick;
                    end
                end
                ACCESS: begin
                    s_we <= 1'b0;
                    if (wait_cnt == 4'd0) begin
                        if (grant) begin
                            m1_rdata <= s_unmapped ? '0 : s_rdata;
                            m1_ack   <= 1'b1;
                        end else begin
                            m0_rdata <= s_unmapped ? '0 : s_rdata;
                            m0_ack   <= 1'b1;
                        end
                        state <= ACK;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ACK: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter: single accesses, round-robin contention,
// unmapped handling, back-to-back reads and asynchronous reset mid-transaction.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ack, m1_ack;
    logic        s_we;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        busy;

    int vectors;
    int miscompares;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .IO_WAIT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack),
        .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one request at a negedge and follows it to its ack, recording the bus activity seen.
    task automatic run_txn(input bit m, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           output int lat, output int we_cnt, output int busy_cnt, output bit other_ack,
                           output logic [31:0] first_addr, output logic [31:0] we_addr,
                           output logic [31:0] we_data);
        lat = 0; we_cnt = 0; busy_cnt = 0; other_ack = 1'b0;
        first_addr = '0; we_addr = '0; we_data = '0;
        if (!m) begin
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 1) first_addr = s_addr;
            if (s_we) begin
                we_cnt++; we_addr = s_addr; we_data = s_wdata;
            end
            if (busy) busy_cnt++;
            if (m ? m0_ack : m1_ack) other_ack = 1'b1;
            if (m ? m1_ack : m0_ack) break;
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        s_rdata = 0;
        repeat (2) @(negedge clk);
        vectors++; if (s_we !== 1'b0) begin miscompares++; $display("FAIL reset_s_we got %b want 0", s_we); end
        vectors++; if (s_addr !== 32'h0) begin miscompares++; $display("FAIL reset_s_addr got %h want 0", s_addr); end
        vectors++; if (s_wdata !== 32'h0) begin miscompares++; $display("FAIL reset_s_wdata got %h want 0", s_wdata); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if ({m0_ack, m1_ack} !== 2'b00) begin miscompares++; $display("FAIL reset_acks got %b want 00", {m0_ack, m1_ack}); end
        vectors++; if ({m0_rdata, m1_rdata} !== 64'h0) begin miscompares++; $display("FAIL reset_rdata got %h want 0", {m0_rdata, m1_rdata}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ram_read();
        int lat, we_cnt, busy_cnt; bit other; logic [31:0] fa, wa, wd;
        s_rdata = 32'hDEAD_BEEF;
        run_txn(1'b0, 1'b0, 32'h010, 32'h0, lat, we_cnt, busy_cnt, other, fa, wa, wd);
        vectors++; if (fa !== 32'h010) begin miscompares++; $display("FAIL ram_s_addr got %h want 010", fa); end
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL ram_latency got %0d want 2", lat); end
        vectors++; if (m0_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL ram_rdata got %h want deadbeef", m0_rdata); end
        vectors++; if (other !== 1'b0) begin miscompares++; $display("FAIL ram_m1_ack got %b want 0", other); end
        vectors++; if (we_cnt !== 0) begin miscompares++; $display("FAIL ram_s_we got %0d pulses want 0", we_cnt); end
        vectors++; if ({busy, m0_ack} !== 2'b00) begin miscompares++; $display("FAIL ram_idle got %b want 00", {busy, m0_ack}); end
    endtask

    task automatic test_io_write();
        int lat, we_cnt, busy_cnt; bit other; logic [31:0] fa, wa, wd;
        run_txn(1'b1, 1'b1, 32'h104, 32'h5A, lat, we_cnt, busy_cnt, other, fa, wa, wd);
        vectors++; if (we_cnt !== 1) begin miscompares++; $display("FAIL io_we_pulses got %0d want 1", we_cnt); end
        vectors++; if (wa !== 32'h104) begin miscompares++; $display("FAIL io_we_addr got %h want 104", wa); end
        vectors++; if (wd !== 32'h5A) begin miscompares++; $display("FAIL io_we_data got %h want 5a", wd); end
        vectors++; if (lat !== 4) begin miscompares++; $display("FAIL io_latency got %0d want 4", lat); end
        vectors++; if (busy_cnt !== 4) begin miscompares++; $display("FAIL io_busy_cycles got %0d want 4", busy_cnt); end
        vectors++; if (other !== 1'b0) begin miscompares++; $display("FAIL io_m0_ack got %b want 0", other); end
    endtask

    task automatic test_unmapped();
        int lat, we_cnt, busy_cnt; bit other; logic [31:0] fa, wa, wd;
        run_txn(1'b0, 1'b1, 32'h200, 32'h77, lat, we_cnt, busy_cnt, other, fa, wa, wd);
        vectors++; if (we_cnt !== 0) begin miscompares++; $display("FAIL unmapped_we got %0d pulses want 0", we_cnt); end
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL unmapped_wr_latency got %0d want 2", lat); end
        s_rdata = 32'h1234_5678;
        run_txn(1'b0, 1'b0, 32'h200, 32'h0, lat, we_cnt, busy_cnt, other, fa, wa, wd);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL unmapped_rd_latency got %0d want 2", lat); end
        vectors++; if (m0_rdata !== 32'h0) begin miscompares++; $display("FAIL unmapped_rdata got %h want 0", m0_rdata); end
        run_txn(1'b0, 1'b0, 32'h1FF, 32'h0, lat, we_cnt, busy_cnt, other, fa, wa, wd);
        vectors++; if (lat !== 4) begin miscompares++; $display("FAIL io_top_latency got %0d want 4", lat); end
        vectors++; if (m0_rdata !== 32'h1234_5678) begin miscompares++; $display("FAIL io_top_rdata got %h want 12345678", m0_rdata); end
    endtask

    task automatic test_round_robin();
        bit order[4]; int when[4]; int acks = 0; int n = 0; int dual = 0; int n0 = 0;
        s_rdata = 32'h1111_1111;
        m0_req = 1; m0_we = 0; m0_addr = 32'h020;
        m1_req = 1; m1_we = 0; m1_addr = 32'h030;
        while (acks < 4 && n < 60) begin
            @(negedge clk);
            n++;
            if (m0_ack && m1_ack) dual++;
            if (m0_ack || m1_ack) begin
                order[acks] = m1_ack; when[acks] = n; acks++;
                if (!m1_ack) n0++;
            end
            if (acks == 4) begin m0_req = 0; m1_req = 0; end
        end
        m0_req = 0; m1_req = 0;
        @(negedge clk);
        vectors++; if (acks !== 4) begin miscompares++; $display("FAIL rr_ack_count got %0d want 4", acks); end
        vectors++; if (dual !== 0) begin miscompares++; $display("FAIL rr_dual_ack got %0d want 0", dual); end
        vectors++; if (n0 !== 2) begin miscompares++; $display("FAIL rr_m0_acks got %0d want 2", n0); end
        if (acks == 4) begin
            vectors++; if ({order[0], order[1], order[2], order[3]} !== 4'b0101) begin miscompares++;
                $display("FAIL rr_order got %b want 0101", {order[0], order[1], order[2], order[3]}); end
            vectors++; if (when[3] - when[0] !== 9) begin miscompares++; $display("FAIL rr_spacing got %0d want 9", when[3] - when[0]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp = 32'h0000_1000; int acks = 0; int n = 0; int last = 0;
        s_rdata = exp;
        m0_req = 1; m0_we = 0; m0_addr = 32'h040;
        while (acks < 3 && n < 40) begin
            @(negedge clk);
            n++;
            if (m0_ack) begin
                vectors++; if (m0_rdata !== exp) begin miscompares++; $display("FAIL b2b_rdata%0d got %h want %h", acks, m0_rdata, exp); end
                if (acks > 0) begin
                    vectors++; if (n - last !== 3) begin miscompares++; $display("FAIL b2b_spacing%0d got %0d want 3", acks, n - last); end
                end
                last = n; acks++;
                exp = exp + 32'h1; s_rdata = exp;
                if (acks == 3) m0_req = 0;
            end
        end
        m0_req = 0;
        @(negedge clk);
        vectors++; if (acks !== 3) begin miscompares++; $display("FAIL b2b_ack_count got %0d want 3", acks); end
    endtask

    task automatic test_reset_mid();
        int lat, we_cnt, busy_cnt; bit other; logic [31:0] fa, wa, wd; int stray = 0;
        s_rdata = 32'hBAD0_BAD0;
        m1_req = 1; m1_we = 0; m1_addr = 32'h108; m1_wdata = 32'h99;
        repeat (3) @(negedge clk);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy_before got %b want 1", busy); end
        rst_n = 0;
        m1_req = 0;
        #1;
        vectors++; if ({busy, s_we, m0_ack, m1_ack} !== 4'b0000) begin miscompares++;
            $display("FAIL mid_ctrl got %b want 0000", {busy, s_we, m0_ack, m1_ack}); end
        vectors++; if ({s_addr, s_wdata} !== 64'h0) begin miscompares++; $display("FAIL mid_bus got %h want 0", {s_addr, s_wdata}); end
        vectors++; if ({m0_rdata, m1_rdata} !== 64'h0) begin miscompares++; $display("FAIL mid_rdata got %h want 0", {m0_rdata, m1_rdata}); end
        repeat (2) begin @(negedge clk); if (m1_ack) stray++; end
        rst_n = 1;
        repeat (3) begin @(negedge clk); if (m1_ack) stray++; end
        vectors++; if (stray !== 0) begin miscompares++; $display("FAIL mid_no_ack got %0d acks want 0", stray); end
        s_rdata = 32'hCAFE_F00D;
        run_txn(1'b1, 1'b0, 32'h108, 32'h0, lat, we_cnt, busy_cnt, other, fa, wa, wd);
        vectors++; if (lat !== 4) begin miscompares++; $display("FAIL mid_fresh_latency got %0d want 4", lat); end
        vectors++; if (m1_rdata !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL mid_fresh_rdata got %h want cafef00d", m1_rdata); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_ram_read();
        test_io_write();
        test_unmapped();
        test_round_robin();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single data-memory bus (RAM 0x000–0x0FF, I/O 0x100–0x1FF) between two requesters: m0 = pipeline MEM stage, m1 = debug/loader port.
- Provides round-robin arbitration, a req/ack handshake per requester, and fixed extra wait states for I/O-space accesses.
- Sits between the requesters and the downstream address decoder / read mux.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- IO_WAIT, 2, extra access cycles added to any I/O-space access (0–15 legal).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- m0_req  input  1  m0 access request.
- m0_we  input  1  m0 write enable (1 = write, 0 = read).
- m0_addr  input  ADDR_W  m0 byte address.
- m0_wdata  input  DATA_W  m0 write data.
- m0_rdata  output  DATA_W  m0 read data, valid while m0_ack is high.
- m0_ack  output  1  m0 completion pulse.
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack: same as the m0 ports, for m1.
- s_we  output  1  downstream write strobe.
- s_addr  output  ADDR_W  downstream address.
- s_wdata  output  DATA_W  downstream write data.
- s_rdata  input  DATA_W  downstream read data, combinational from the read mux.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - s_we=0, s_addr=0, s_wdata=0.
  - m0_ack=m1_ack=0, m0_rdata=m1_rdata=0, busy=0.
  - last_grant=1, so m0 wins the first contested cycle.
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - Sample m0_req/m1_req on each rising edge.
  - One request pending: grant that requester.
  - Both pending: grant the requester that is not last_grant, then update last_grant.
  - On grant: register that requester's addr/we/wdata into s_addr/s_we/s_wdata, load the wait counter, go to ACCESS.
- Address classes, decoded from the registered address:
  - RAM: addr ≤ 0xFF. 1 ACCESS cycle.
  - I/O: 0x100 ≤ addr ≤ 0x1FF. 1+IO_WAIT ACCESS cycles.
  - Unmapped: anything else. 1 ACCESS cycle; s_we forced 0; returned rdata = 0.
- ACCESS:
  - s_we is high only in the first ACCESS cycle, and only for a mapped write. It is cleared on the next edge.
  - s_addr and s_wdata stay stable for the whole access.
  - The wait counter decrements each cycle.
  - On the last ACCESS cycle: capture s_rdata (or 0 if unmapped) into the granted requester's rdata register, then go to ACK.
- ACK:
  - Granted requester's ack=1 for exactly one cycle; its rdata is valid during that cycle.
  - Next state is IDLE.
  - rdata holds its value until the next completion for that requester.
- Latency from the edge that samples req to ack high:
  - RAM: 2 cycles.
  - I/O: 2+IO_WAIT cycles.
  - Minimum request-to-request period: 3 cycles.
- Requester rules:
  - Hold req, we, addr and wdata stable from assertion until the ack cycle.
  - A req still high in the cycle after ack is treated as a new request, sampled in IDLE.
  - A req dropped before ack is a protocol violation. The transaction is not cancelled.
- Only the granted requester ever sees ack. The non-granted requester's req stays pending; it is not lost.
- Write data is never acked before the write strobe has been issued.
- Reset mid-operation: the transaction is abandoned immediately, no ack is issued, and all outputs take their reset values.
- Width rules:
  - Address decode uses the full ADDR_W compare.
  - No address translation is done here; the downstream decoder handles offsets.

Test Plan:
1. m0 read of RAM 0x010, s_rdata=0xDEADBEEF -> s_addr=0x010 in ACCESS; m0_ack high 2 cycles after sampling; m0_rdata=0xDEADBEEF; m1_ack stays 0.
2. m1 write to I/O 0x104, wdata 0x5A, IO_WAIT=2 -> s_we high exactly 1 cycle with s_addr=0x104 and s_wdata=0x5A; m1_ack 4 cycles after sampling; busy high 4 cycles.
3. m0_req and m1_req asserted together and held through 4 transactions -> grant order m0, m1, m0, m1; each requester receives exactly 2 acks; no two acks in the same cycle.
4. m0 write to unmapped 0x200 -> s_we never asserts; m0_ack after 2 cycles; m0_rdata=0 for a read variant.
5. rst_n pulled low during the second I/O wait cycle of an m1 read -> no m1_ack; all outputs 0 immediately (async); after release, a fresh m1 request completes normally.
6. Back-to-back m0 RAM reads with req held high -> acks spaced every 3 cycles; m0_rdata updates on each ack.
